serial_add_sub_ctrl: RTL and testbench
======================================

SERIAL_ADD_SUB_CTRL -- requirements
Module: serial_add_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request to launch one operation; sampled only in IDLE.
REQ-005 sel  input  1  operation select: 0 = add, 1 = subtract.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  initial carry (add) or initial borrow (subtract).
REQ-009 busy  output  1  high while bits are being processed.
REQ-010 done  output  1  one-cycle pulse marking that result, cout and ovf are updated.
REQ-011 result  output  WIDTH  registered sum or difference.
REQ-012 cout  output  1  final carry-out (add) or borrow-out (subtract).
REQ-013 ovf  output  1  signed two's-complement overflow flag.

Function
REQ-014 The block SHALL compute the result bit-serially, LSB first, through one internal 1-bit full adder/subtractor slice with a registered carry/borrow.
REQ-015 Slice, add: s = a^b^c; c_next = ab | ac | bc.
REQ-016 Slice, subtract: d = a^b^c; c_next = (~a&b) | (~a&c) | (b&c), where c is the borrow.
REQ-017 The FSM SHALL have exactly three states, IDLE, RUN and DONE, encoded as 2 bits.
REQ-018 IDLE with start=1 at edge E0: latch a, b and sel; load the carry register from cin; clear the bit counter; go to RUN; busy=1.
REQ-019 RUN: each edge processes the bit at the counter position, shifts it into the internal result shift register, updates the carry register and increments the counter.
REQ-020 After the WIDTH-th bit edge (E0+WIDTH), the block SHALL go to DONE with busy=0 and done=1, and update result, cout and ovf at that same edge.
REQ-021 DONE SHALL last exactly one cycle and then return unconditionally to IDLE, so done is a single-cycle pulse.
REQ-022 Latency: outputs are valid WIDTH edges after the start sample; the next operation can be accepted no earlier than edge E0+WIDTH+2.
REQ-023 start asserted in RUN or DONE SHALL be ignored: not queued, and no effect on the latched operands.
REQ-024 Changes on a, b, sel or cin after E0 SHALL NOT affect the operation in progress.
REQ-025 result, cout and ovf SHALL hold their values from the last completion until the next completion edge, including through IDLE and RUN.
REQ-026 Add arithmetic: {cout, result} = A + B + cin, modulo 2^(WIDTH+1).
REQ-027 Subtract arithmetic: result = (A - B - cin) mod 2^WIDTH; cout = 1 iff A < B + cin, unsigned.
REQ-028 ovf = 1 iff the exact signed result (A±B, ∓cin applied) lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-029 ovf SHALL be derived as the MSB carry-in XOR the MSB carry-out of the chain.
REQ-030 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during RUN.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force: state IDLE, busy=0, done=0, result=0, cout=0, ovf=0, counter=0, carry register=0, internal shift register=0.
REQ-032 Reset asserted mid-RUN SHALL abort the operation with no done pulse and no partial result visible.
REQ-033 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-034 Add: a=0x35, b=0x4A, cin=0, sel=0 -> result 0x7F, cout 0, ovf 0; done exactly 8 edges after start; busy high for 8 cycles.
REQ-035 Add wrap: a=0xFF, b=0x01, cin=0 -> result 0x00, cout 1, ovf 0. Signed overflow: a=0x7F, b=0x00, cin=1 -> result 0x80, cout 0, ovf 1.
REQ-036 Subtract: a=0x05, b=0x07, cin=0, sel=1 -> result 0xFE, cout 1, ovf 0. Borrow-in: a=0x10, b=0x00, cin=1 -> result 0x0F, cout 0, ovf 0.
REQ-037 Subtract overflow: a=0x80, b=0x01, sel=1 -> result 0x7F, cout 0, ovf 1.
REQ-038 Busy-ignore: pulse start with new operands on the 3rd RUN cycle -> the original result completes unchanged, with one done pulse only.
REQ-039 Reset mid-op: drop rst_n on the 4th RUN cycle -> all outputs are 0 immediately, with no done pulse. After release, a=0x01, b=0x01, add -> result 0x02.

Source files
------------

// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl: bit-serial adder/subtractor with a three-state controller.
// A single 1-bit full adder/subtractor slice walks the operands LSB first with a
// registered carry (add) or borrow (subtract). The result, carry/borrow-out and
// signed overflow are published together with a one-cycle done pulse.

module serial_add_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    // Counter holds 0..WIDTH, so it never has to wrap while bits are in flight.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic             sel_q,    sel_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] sr_q,     sr_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic             bit_a;
    logic             bit_b;
    logic             sum_bit;
    logic             carry_next;
    logic             last_bit;

    // The 1-bit slice: operands are shifted right each bit, so bit 0 of the
    // latched copies is always the bit at the current counter position.
    always_comb begin
        bit_a   = a_sh_q[0];
        bit_b   = b_sh_q[0];
        sum_bit = bit_a ^ bit_b ^ carry_q;
        if (sel_q) begin
            carry_next = (~bit_a & bit_b) | (~bit_a & carry_q) | (bit_b & carry_q);
        end else begin
            carry_next = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
        end
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sel_d    = sel_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    sel_d   = sel;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end

            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                sr_d    = WIDTH'({sum_bit, sr_q} >> 1);
                carry_d = carry_next;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    // On the MSB, carry_q is the carry into the MSB, so the
                    // overflow flag is simply in-carry XOR out-carry.
                    result_d = WIDTH'({sum_bit, sr_q} >> 1);
                    cout_d   = carry_next;
                    ovf_d    = carry_q ^ carry_next;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state and registered outputs, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sel_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sr_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sel_q    <= sel_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Directed testbench for serial_add_sub_ctrl at WIDTH=8 with hand-computed
// expected values for add, subtract, busy-ignore, reset and back-to-back cases.

module tb_serial_add_sub_ctrl;

    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic             sel   = 1'b0;
    logic             cin   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int n_compared   = 0;
    int n_mismatched = 0;

    serial_add_sub_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sel    (sel),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Hard stop in case something stalls far beyond any test's length.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Launch one operation and observe it for 'window' edges after the start edge.
    // Operands are scrambled right after the start edge; inject_at pulses start
    // with different operands just before that edge number.
    task automatic do_op(input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic op_sel, input logic op_cin,
                         input int window, input int inject_at,
                         output int done_edge, output int busy_cnt, output int done_cnt,
                         output logic [7:0] r_res, output logic r_cout, output logic r_ovf,
                         output logic [7:0] end_res);
        a = op_a; b = op_b; sel = op_sel; cin = op_cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~op_a; b = op_b ^ 8'h5A; sel = ~op_sel; cin = ~op_cin;
        done_edge = -1; done_cnt = 0; busy_cnt = busy ? 1 : 0;
        r_res = '0; r_cout = 1'b0; r_ovf = 1'b0;
        if (done) done_cnt++;
        for (int i = 1; i <= window; i++) begin
            if (i == inject_at) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; sel = 1'b1; cin = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = i; r_res = result; r_cout = cout; r_ovf = ovf;
                end
            end
        end
        end_res = result;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_compared++;
        if ({busy, done, cout, ovf, result} !== 12'h000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_async: got %h expected %h", {busy, done, cout, ovf, result}, 12'h000);
        end
        repeat (2) @(posedge clk);
        #1;
        n_compared++;
        if ({busy, done, cout, ovf, result} !== 12'h000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_held: got %h expected %h", {busy, done, cout, ovf, result}, 12'h000);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [7:0] va [4] = '{8'h35, 8'hFF, 8'h7F, 8'h80};
        logic [7:0] vb [4] = '{8'h4A, 8'h01, 8'h00, 8'h80};
        logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] er [4] = '{8'h7F, 8'h00, 8'h80, 8'h00};
        logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int de, bc, dc;
        logic [7:0] rr, hr;
        logic rc, ro;
        for (int k = 0; k < 4; k++) begin
            do_op(va[k], vb[k], 1'b0, vc[k], 12, -1, de, bc, dc, rr, rc, ro, hr);
            n_compared++;
            if (de !== 8) begin n_mismatched++; $display("[TB] FAIL add%0d_latency: got %0d expected 8", k, de); end
            n_compared++;
            if (bc !== 8) begin n_mismatched++; $display("[TB] FAIL add%0d_busy_cycles: got %0d expected 8", k, bc); end
            n_compared++;
            if (dc !== 1) begin n_mismatched++; $display("[TB] FAIL add%0d_done_pulses: got %0d expected 1", k, dc); end
            n_compared++;
            if (rr !== er[k]) begin n_mismatched++; $display("[TB] FAIL add%0d_result: got %h expected %h", k, rr, er[k]); end
            n_compared++;
            if (rc !== ec[k]) begin n_mismatched++; $display("[TB] FAIL add%0d_cout: got %b expected %b", k, rc, ec[k]); end
            n_compared++;
            if (ro !== eo[k]) begin n_mismatched++; $display("[TB] FAIL add%0d_ovf: got %b expected %b", k, ro, eo[k]); end
            n_compared++;
            if (hr !== er[k]) begin n_mismatched++; $display("[TB] FAIL add%0d_hold: got %h expected %h", k, hr, er[k]); end
        end
    endtask

    task automatic test_sub();
        logic [7:0] va [4] = '{8'h05, 8'h10, 8'h80, 8'h00};
        logic [7:0] vb [4] = '{8'h07, 8'h00, 8'h01, 8'hFF};
        logic       vc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [7:0] er [4] = '{8'hFE, 8'h0F, 8'h7F, 8'h00};
        logic       ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int de, bc, dc;
        logic [7:0] rr, hr;
        logic rc, ro;
        for (int k = 0; k < 4; k++) begin
            do_op(va[k], vb[k], 1'b1, vc[k], 12, -1, de, bc, dc, rr, rc, ro, hr);
            n_compared++;
            if (de !== 8) begin n_mismatched++; $display("[TB] FAIL sub%0d_latency: got %0d expected 8", k, de); end
            n_compared++;
            if (dc !== 1) begin n_mismatched++; $display("[TB] FAIL sub%0d_done_pulses: got %0d expected 1", k, dc); end
            n_compared++;
            if (rr !== er[k]) begin n_mismatched++; $display("[TB] FAIL sub%0d_result: got %h expected %h", k, rr, er[k]); end
            n_compared++;
            if (rc !== ec[k]) begin n_mismatched++; $display("[TB] FAIL sub%0d_cout: got %b expected %b", k, rc, ec[k]); end
            n_compared++;
            if (ro !== eo[k]) begin n_mismatched++; $display("[TB] FAIL sub%0d_ovf: got %b expected %b", k, ro, eo[k]); end
        end
    endtask

    task automatic test_busy_ignore();
        int de, bc, dc;
        logic [7:0] rr, hr;
        logic rc, ro;
        do_op(8'h12, 8'h34, 1'b0, 1'b0, 14, 3, de, bc, dc, rr, rc, ro, hr);
        n_compared++;
        if (de !== 8) begin n_mismatched++; $display("[TB] FAIL busy_ignore_latency: got %0d expected 8", de); end
        n_compared++;
        if (dc !== 1) begin n_mismatched++; $display("[TB] FAIL busy_ignore_done_pulses: got %0d expected 1", dc); end
        n_compared++;
        if ({rr, rc, ro} !== {8'h46, 1'b0, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL busy_ignore_result: got %h/%b/%b expected 46/0/0", rr, rc, ro);
        end
        n_compared++;
        if (hr !== 8'h46) begin n_mismatched++; $display("[TB] FAIL busy_ignore_hold: got %h expected 46", hr); end
    endtask

    task automatic test_reset_mid_op();
        int de, bc, dc;
        int seen_done;
        logic [7:0] rr, hr;
        logic rc, ro;
        a = 8'h22; b = 8'h11; sel = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        n_compared++;
        if ({busy, done, cout, ovf, result} !== 12'h000) begin
            n_mismatched++;
            $display("[TB] FAIL midop_reset_async: got %h expected %h", {busy, done, cout, ovf, result}, 12'h000);
        end
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy || result != 8'h00) seen_done++;
        end
        n_compared++;
        if (seen_done !== 0) begin n_mismatched++; $display("[TB] FAIL midop_no_activity: got %0d expected 0", seen_done); end
        rst_n = 1'b1;
        do_op(8'h01, 8'h01, 1'b0, 1'b0, 12, -1, de, bc, dc, rr, rc, ro, hr);
        n_compared++;
        if (de !== 8) begin n_mismatched++; $display("[TB] FAIL post_reset_latency: got %0d expected 8", de); end
        n_compared++;
        if ({rr, rc, ro} !== {8'h02, 1'b0, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_result: got %h/%b/%b expected 02/0/0", rr, rc, ro);
        end
    endtask

    task automatic test_back_to_back();
        int de, bc, dc;
        logic [7:0] rr, hr;
        logic rc, ro;
        do_op(8'h80, 8'h80, 1'b0, 1'b0, 9, -1, de, bc, dc, rr, rc, ro, hr);
        n_compared++;
        if ({rr, rc, ro} !== {8'h00, 1'b1, 1'b1}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_first: got %h/%b/%b expected 00/1/1", rr, rc, ro);
        end
        do_op(8'h3C, 8'h0F, 1'b1, 1'b0, 12, -1, de, bc, dc, rr, rc, ro, hr);
        n_compared++;
        if (de !== 8) begin n_mismatched++; $display("[TB] FAIL b2b_second_latency: got %0d expected 8", de); end
        n_compared++;
        if ({rr, rc, ro} !== {8'h2D, 1'b0, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_second: got %h/%b/%b expected 2D/0/0", rr, rc, ro);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] starting serial_add_sub_ctrl bench");
        test_reset();
        test_add();
        test_sub();
        test_busy_ignore();
        test_reset_mid_op();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
